// File: rtl/senone_normaliser_if.sv
// Handshake bundle between the GDP controller, the senone normaliser and the
// search/HMM consumer. Upstream/consumer side drives through master.
interface senone_normaliser_if;
    logic               score_ready;
    logic [7:0]         senone_idx;
    logic signed [15:0] senone_score;
    logic               last_senone;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_idx;
    logic signed [15:0] out_score;
    logic               frame_done;
    logic               overrun;

    modport master (
        output score_ready, senone_idx, senone_score, last_senone, out_ready,
        input  busy, out_valid, out_idx, out_score, frame_done, overrun
    );

    modport slave (
        input  score_ready, senone_idx, senone_score, last_senone, out_ready,
        output busy, out_valid, out_idx, out_score, frame_done, overrun
    );
endinterface

// File: rtl/senone_normaliser.sv
// Captures one frame of senone scores, tracks the frame maximum, then streams
// score - best per senone. Define NORM_CLAMP_EN to clamp outputs at SCORE_FLOOR.
module senone_normaliser #(
    parameter int                 N_SENONES   = 10,
    parameter logic signed [15:0] SCORE_FLOOR = -16'sd8192
) (
    input  logic               clk,
    input  logic               reset,
    senone_normaliser_if.slave norm_if
);

    localparam int         AW       = (N_SENONES > 1) ? $clog2(N_SENONES) : 1;
    localparam logic [7:0] LAST_IDX = 8'(N_SENONES - 1);
    localparam logic [8:0] N_LIM    = 9'(N_SENONES);
`ifdef NORM_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t             state_q;
    logic [7:0]         rd_ptr_q;
    logic signed [15:0] best_q;
    logic               have_best_q;
    logic               frame_done_q;
    logic               overrun_q;
    logic signed [15:0] mem_q [N_SENONES];

    logic               idx_ok_d;
    logic signed [16:0] diff_d;
    logic signed [15:0] sat_d;
    logic signed [15:0] norm_d;

    assign idx_ok_d = ({1'b0, norm_if.senone_idx} < N_LIM);

    // Score storage has no reset: contents are undefined until written.
    always_ff @(posedge clk) begin
        if (state_q == COLLECT && norm_if.score_ready && idx_ok_d) begin
            mem_q[norm_if.senone_idx[AW-1:0]] <= norm_if.senone_score;
        end
    end

    always_comb begin
        diff_d = $signed({mem_q[rd_ptr_q[AW-1:0]][15], mem_q[rd_ptr_q[AW-1:0]]})
               - $signed({best_q[15], best_q});
        // Stale entries could exceed best, so saturate in both directions.
        if (diff_d < -17'sd32768) begin
            sat_d = -16'sd32768;
        end else if (diff_d > 17'sd32767) begin
            sat_d = 16'sd32767;
        end else begin
            sat_d = diff_d[15:0];
        end
        norm_d = sat_d;
        if (CLAMP_ON && (sat_d < SCORE_FLOOR)) begin
            norm_d = SCORE_FLOOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= COLLECT;
            rd_ptr_q     <= 8'd0;
            best_q       <= 16'sd0;
            have_best_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (norm_if.score_ready) begin
                        if (idx_ok_d && (!have_best_q || norm_if.senone_score > best_q)) begin
                            best_q      <= norm_if.senone_score;
                            have_best_q <= 1'b1;
                        end
                        if (norm_if.last_senone) begin
                            state_q  <= DRAIN;
                            rd_ptr_q <= 8'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (norm_if.score_ready) begin
                        overrun_q <= 1'b1;
                    end
                    if (norm_if.out_ready) begin
                        if (rd_ptr_q == LAST_IDX) begin
                            state_q      <= COLLECT;
                            rd_ptr_q     <= 8'd0;
                            have_best_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign norm_if.busy       = (state_q == DRAIN);
    assign norm_if.out_valid  = (state_q == DRAIN);
    assign norm_if.out_idx    = rd_ptr_q;
    assign norm_if.out_score  = (state_q == DRAIN) ? norm_d : 16'sd0;
    assign norm_if.frame_done = frame_done_q;
    assign norm_if.overrun    = overrun_q;

endmodule

// File: tb/tb_senone_normaliser.sv
// Self-checking bench for senone_normaliser: randomised frames compared
// against a per-frame max/subtract reference model.
module tb_senone_normaliser;

    localparam int N     = 4;
    localparam int FLOOR = -8192;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    senone_normaliser_if bus ();

    senone_normaliser #(
        .N_SENONES   (N),
        .SCORE_FLOOR (-16'sd8192)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .norm_if (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int mdl_mem [N];
    int mdl_best;
    bit mdl_have;
    bit mdl_ovr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_score();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    function automatic int expect_score(int k);
        int d;
        d = mdl_mem[k] - mdl_best;
        if (d < -32768) d = -32768;
`ifdef NORM_CLAMP_EN
        if (d < FLOOR) d = FLOOR;
`endif
        return d;
    endfunction

    task automatic send_score(int idx, int score, bit last);
        bus.score_ready  = 1'b1;
        bus.senone_idx   = 8'(idx);
        bus.senone_score = 16'(score);
        bus.last_senone  = last;
        tick();
        bus.score_ready = 1'b0;
        bus.last_senone = 1'b0;
        if (idx < N) begin
            mdl_mem[idx] = score;
            if (!mdl_have || score > mdl_best) mdl_best = score;
            mdl_have = 1'b1;
        end
        checks++;
        if (bus.busy !== last) begin
            errors++;
            $display("FAIL collect_busy idx=%0d: got %b expected %b", idx, bus.busy, last);
        end
    endtask

    task automatic drain_frame(int stall_idx, int stall_cycles, bit do_ovr);
        int exp;
        for (int k = 0; k < N; k++) begin
            exp = expect_score(k);
            if (k == stall_idx) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    bus.out_ready = 1'b0;
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_idx !== 8'(k) || bus.out_score !== 16'(exp)) begin
                        errors++;
                        $display("FAIL stall_hold k=%0d: got v=%b idx=%0d score=%0d expected v=1 idx=%0d score=%0d",
                                 k, bus.out_valid, bus.out_idx, bus.out_score, k, exp);
                    end
                    checks++;
                    if (bus.overrun !== mdl_ovr) begin
                        errors++;
                        $display("FAIL overrun_stall k=%0d: got %b expected %b", k, bus.overrun, mdl_ovr);
                    end
                    if (do_ovr && c == 0) begin
                        bus.score_ready  = 1'b1;
                        bus.senone_idx   = 8'(k);
                        bus.senone_score = 16'sd1000;
                        mdl_ovr          = 1'b1;
                    end
                    tick();
                    bus.score_ready = 1'b0;
                end
            end
            bus.out_ready = 1'b1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid k=%0d: got v=%b busy=%b expected 1 1", k, bus.out_valid, bus.busy);
            end
            checks++;
            if (bus.out_idx !== 8'(k)) begin
                errors++;
                $display("FAIL drain_idx: got %0d expected %0d", bus.out_idx, k);
            end
            checks++;
            if (bus.out_score !== 16'(exp)) begin
                errors++;
                $display("FAIL drain_score k=%0d: got %0d expected %0d", k, bus.out_score, exp);
            end
            checks++;
            if (bus.overrun !== mdl_ovr) begin
                errors++;
                $display("FAIL overrun k=%0d: got %b expected %b", k, bus.overrun, mdl_ovr);
            end
            $display("out idx=%0d score=%0d (model %0d)", bus.out_idx, bus.out_score, exp);
            tick();
        end
        bus.out_ready = 1'b0;
        mdl_have = 1'b0;
        checks++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: got done=%b busy=%b valid=%b expected 1 0 0",
                     bus.frame_done, bus.busy, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse: got %b expected 0", bus.frame_done);
        end
    endtask

    task automatic run_frame(int s[N], int stall_idx, int stall_cycles, bit do_ovr);
        for (int i = 0; i < N; i++) send_score(i, s[i], i == N - 1);
        drain_frame(stall_idx, stall_cycles, do_ovr);
    endtask

    task automatic test_reset();
        bus.score_ready = 1'b0; bus.senone_idx = 8'd0; bus.senone_score = 16'sd0;
        bus.last_senone = 1'b0; bus.out_ready = 1'b0;
        mdl_have = 1'b0; mdl_ovr = 1'b0; mdl_best = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.out_valid, bus.frame_done, bus.overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.busy, bus.out_valid, bus.frame_done, bus.overrun});
        end
        checks++;
        if (bus.out_idx !== 8'd0 || bus.out_score !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outs: got idx=%0d score=%0d expected 0 0", bus.out_idx, bus.out_score);
        end
    endtask

    task automatic test_basic();
        int fr[N];
        fr = '{100, 300, -50, 200};
        run_frame(fr, -1, 0, 1'b0);
    endtask

    task automatic test_saturation();
        int fr[N];
        fr = '{32767, -32768, 0, -1};
        run_frame(fr, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        int fr[N];
        for (int i = 0; i < N; i++) fr[i] = rand_score();
        run_frame(fr, 1, 3, 1'b0);
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < N; i++) send_score(i, rand_score() / 2, 1'b0);
        send_score(9, 32000, 1'b1);
        drain_frame(-1, 0, 1'b0);
    endtask

    task automatic test_overrun();
        int fr[N];
        for (int i = 0; i < N; i++) fr[i] = rand_score();
        run_frame(fr, 2, 2, 1'b1);
        for (int i = 0; i < N; i++) fr[i] = rand_score();
        run_frame(fr, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int fr[N];
        for (int i = 0; i < N; i++) send_score(i, 5000 + i, i == N - 1);
        bus.out_ready = 1'b1;
        tick(); tick();
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.overrun, bus.frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_flags: got %b expected 0000",
                     {bus.out_valid, bus.busy, bus.overrun, bus.frame_done});
        end
        checks++;
        if (bus.out_idx !== 8'd0 || bus.out_score !== 16'sd0) begin
            errors++;
            $display("FAIL reset_mid_outs: got idx=%0d score=%0d expected 0 0", bus.out_idx, bus.out_score);
        end
        mdl_ovr = 1'b0; mdl_have = 1'b0;
        #1 reset = 1'b0;
        tick();
        fr = '{-10, -20, -30, -40};
        run_frame(fr, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int fr[N];
        fr = '{-500, -500, -500, -500};
        run_frame(fr, -1, 0, 1'b0);
        fr = '{50, 40, 45, 10};
        run_frame(fr, -1, 0, 1'b0);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) fr[i] = rand_score();
            run_frame(fr, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_out_of_range();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
